// File: rtl/ps2_mouse_packet_decoder_if.sv
// rtl/ps2_mouse_packet_decoder_if.sv - byte stream in / decoded packet and cursor out
//
// Ports:
//   received_data, received_data_en : byte stream from the PS/2 receiver
//   recenter                        : request to put the cursor back at its home position
//   pkt_valid, btn_*, dx, dy, *_ovf : decoded packet fields
//   cursor_x, cursor_y              : clamped cursor position
//   sync_err                        : saturating count of discarded bytes and timeouts
// modport master: byte source / packet consumer side; modport slave: the decoder.
interface ps2_mouse_packet_decoder_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic [7:0]     received_data;
    logic           received_data_en;
    logic           recenter;
    logic           pkt_valid;
    logic           btn_left;
    logic           btn_right;
    logic           btn_middle;
    logic [8:0]     dx;
    logic [8:0]     dy;
    logic           x_ovf;
    logic           y_ovf;
    logic [X_W-1:0] cursor_x;
    logic [Y_W-1:0] cursor_y;
    logic [7:0]     sync_err;

    modport master (
        output received_data, received_data_en, recenter,
        input  pkt_valid, btn_left, btn_right, btn_middle, dx, dy,
               x_ovf, y_ovf, cursor_x, cursor_y, sync_err
    );

    modport slave (
        input  received_data, received_data_en, recenter,
        output pkt_valid, btn_left, btn_right, btn_middle, dx, dy,
               x_ovf, y_ovf, cursor_x, cursor_y, sync_err
    );
endinterface

// File: rtl/ps2_mouse_packet_decoder.sv
// rtl/ps2_mouse_packet_decoder.sv - 3-byte PS/2 mouse packet decoder with clamped cursor
//
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous active-high reset
//   bus      : ps2_mouse_packet_decoder_if.slave (byte stream in, decoded packet and cursor out)
// Byte 0 is recognised by bit 3 set; stray bytes and inter-byte timeouts bump sync_err.
module ps2_mouse_packet_decoder #(
    parameter int X_W            = 10,
    parameter int Y_W            = 10,
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int INIT_X         = 320,
    parameter int INIT_Y         = 240,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SHIFT          = 0
) (
    input  logic CLOCK_50,
    input  logic reset,
    ps2_mouse_packet_decoder_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic signed [X_W+1:0] X_MAX = (X_W+2)'(SCREEN_W - 1);
    localparam logic signed [Y_W+1:0] Y_MAX = (Y_W+2)'(SCREEN_H - 1);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // Byte 0 without its always-one sync bit: {y_ovf, x_ovf, y_sign, x_sign, mid, right, left}
    logic [6:0]       hdr_q;
    logic [7:0]       byte1_q;

    logic signed [8:0]     dx_s, dy_s, dx_sh, dy_sh;
    logic signed [X_W+1:0] eff_dx, x_sum;
    logic signed [Y_W+1:0] eff_dy, y_sum;
    logic [X_W-1:0]        x_next;
    logic [Y_W-1:0]        y_next;
    logic                  strobe, expired;

    assign strobe  = bus.received_data_en;
    assign expired = (cnt == CNT_LAST);

    always_comb begin
        dx_s  = {hdr_q[3], byte1_q};
        dy_s  = {hdr_q[4], bus.received_data};
        dx_sh = dx_s >>> SHIFT;
        dy_sh = dy_s >>> SHIFT;
        eff_dx = hdr_q[5] ? '0 : {{(X_W-7){dx_sh[8]}}, dx_sh};
        eff_dy = hdr_q[6] ? '0 : {{(Y_W-7){dy_sh[8]}}, dy_sh};
        // Screen Y grows downward while mouse Y is positive upward.
        x_sum = $signed({2'b00, bus.cursor_x}) + eff_dx;
        y_sum = $signed({2'b00, bus.cursor_y}) - eff_dy;
        if (x_sum[X_W+1])     x_next = '0;
        else if (x_sum > X_MAX) x_next = X_MAX[X_W-1:0];
        else                  x_next = x_sum[X_W-1:0];
        if (y_sum[Y_W+1])     y_next = '0;
        else if (y_sum > Y_MAX) y_next = Y_MAX[Y_W-1:0];
        else                  y_next = y_sum[Y_W-1:0];
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state          <= WAIT_B0;
            cnt            <= '0;
            hdr_q          <= '0;
            byte1_q        <= '0;
            bus.pkt_valid  <= 1'b0;
            bus.btn_left   <= 1'b0;
            bus.btn_right  <= 1'b0;
            bus.btn_middle <= 1'b0;
            bus.dx         <= '0;
            bus.dy         <= '0;
            bus.x_ovf      <= 1'b0;
            bus.y_ovf      <= 1'b0;
            bus.cursor_x   <= X_W'(INIT_X);
            bus.cursor_y   <= Y_W'(INIT_Y);
            bus.sync_err   <= '0;
        end else begin
            bus.pkt_valid <= 1'b0;
            case (state)
                WAIT_B0: begin
                    cnt <= '0;
                    if (strobe) begin
                        if (bus.received_data[3]) begin
                            hdr_q <= {bus.received_data[7:4], bus.received_data[2:0]};
                            state <= WAIT_B1;
                        end else if (bus.sync_err != 8'hFF) begin
                            bus.sync_err <= bus.sync_err + 8'd1;
                        end
                    end
                end
                WAIT_B1, WAIT_B2: begin
                    // A strobe in the expiry cycle is taken; the timeout only fires on an idle cycle.
                    if (strobe) begin
                        cnt <= '0;
                        if (state == WAIT_B1) begin
                            byte1_q <= bus.received_data;
                            state   <= WAIT_B2;
                        end else begin
                            bus.pkt_valid  <= 1'b1;
                            bus.btn_left   <= hdr_q[0];
                            bus.btn_right  <= hdr_q[1];
                            bus.btn_middle <= hdr_q[2];
                            bus.dx         <= dx_s;
                            bus.dy         <= dy_s;
                            bus.x_ovf      <= hdr_q[5];
                            bus.y_ovf      <= hdr_q[6];
                            bus.cursor_x   <= x_next;
                            bus.cursor_y   <= y_next;
                            state          <= WAIT_B0;
                        end
                    end else if (expired) begin
                        cnt   <= '0;
                        state <= WAIT_B0;
                        if (bus.sync_err != 8'hFF)
                            bus.sync_err <= bus.sync_err + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= WAIT_B0;
            endcase
            // Later assignment overrides a same-cycle packet update of the cursor.
            if (bus.recenter) begin
                bus.cursor_x <= X_W'(INIT_X);
                bus.cursor_y <= Y_W'(INIT_Y);
            end
        end
    end
endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// tb/tb_ps2_mouse_packet_decoder.sv - directed bench for ps2_mouse_packet_decoder
module tb_ps2_mouse_packet_decoder;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   hits;

    always #5 clk = ~clk;

    ps2_mouse_packet_decoder_if #(.X_W(10), .Y_W(10)) bus ();

    ps2_mouse_packet_decoder #(
        .X_W(10), .Y_W(10), .SCREEN_W(640), .SCREEN_H(480),
        .INIT_X(320), .INIT_Y(240), .TIMEOUT_CYCLES(TO), .SHIFT(0)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe one byte; returns at the negedge after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.received_data    = b;
        bus.received_data_en = 1'b1;
        @(negedge clk);
        bus.received_data_en = 1'b0;
        bus.received_data    = 8'hA5;
    endtask

    task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send(b0);
        send(b1);
        send(b2);
    endtask

    initial begin
        bus.received_data    = 8'h00;
        bus.received_data_en = 1'b0;
        bus.recenter         = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_pkt_valid", bus.pkt_valid, 0);
        chk("rst_cursor_x", bus.cursor_x, 320);
        chk("rst_cursor_y", bus.cursor_y, 240);
        chk("rst_sync_err", bus.sync_err, 0);
        chk("rst_dx", bus.dx, 0);

        // Basic packet
        pkt(8'h08, 8'h05, 8'h03);
        chk("p1_pkt_valid", bus.pkt_valid, 1);
        chk("p1_dx", bus.dx, 9'h005);
        chk("p1_dy", bus.dy, 9'h003);
        chk("p1_btns", {bus.btn_middle, bus.btn_right, bus.btn_left}, 0);
        chk("p1_cursor_x", bus.cursor_x, 325);
        chk("p1_cursor_y", bus.cursor_y, 237);
        @(negedge clk);
        chk("p1_pulse_end", bus.pkt_valid, 0);
        chk("p1_dx_hold", bus.dx, 9'h005);

        // Left button, negative X
        pkt(8'h19, 8'hFB, 8'h00);
        chk("p2_btn_left", bus.btn_left, 1);
        chk("p2_dx", bus.dx, 9'h1FB);
        chk("p2_dy", bus.dy, 0);
        chk("p2_cursor_x", bus.cursor_x, 320);
        chk("p2_cursor_y", bus.cursor_y, 237);

        // Stray byte then a valid packet with negative Y
        send(8'h00);
        chk("p3_sync_err", bus.sync_err, 1);
        chk("p3_no_pkt", bus.pkt_valid, 0);
        pkt(8'h28, 8'h0A, 8'hF6);
        chk("p3_pkt_valid", bus.pkt_valid, 1);
        chk("p3_dx", bus.dx, 9'h00A);
        chk("p3_dy", bus.dy, 9'h1F6);
        chk("p3_cursor_x", bus.cursor_x, 330);
        chk("p3_cursor_y", bus.cursor_y, 247);

        // Timeout between byte 1 and byte 2
        send(8'h08);
        send(8'h01);
        hits = 0;
        for (int i = 0; i < TO + 3; i++) begin
            @(negedge clk);
            if (bus.pkt_valid) hits++;
        end
        chk("to_no_pkt", hits, 0);
        chk("to_sync_err", bus.sync_err, 2);
        pkt(8'h0A, 8'h02, 8'h02);
        chk("to_pkt_valid", bus.pkt_valid, 1);
        chk("to_btn_right", bus.btn_right, 1);
        chk("to_dx", bus.dx, 9'h002);
        chk("to_cursor_x", bus.cursor_x, 332);
        chk("to_cursor_y", bus.cursor_y, 245);

        // Drive to the bottom-left corner and clamp
        pkt(8'h38, 8'h00, 8'h00);
        chk("cl1_cursor_x", bus.cursor_x, 76);
        chk("cl1_cursor_y", bus.cursor_y, 479);
        pkt(8'h38, 8'h00, 8'h00);
        chk("cl2_cursor_x", bus.cursor_x, 0);
        chk("cl2_cursor_y", bus.cursor_y, 479);
        pkt(8'h38, 8'h9C, 8'h9C);
        chk("cl3_dx", bus.dx, 9'h19C);
        chk("cl3_cursor_x", bus.cursor_x, 0);
        chk("cl3_cursor_y", bus.cursor_y, 479);

        // X overflow suppresses the X move
        pkt(8'h48, 8'h7F, 8'h00);
        chk("ovf_x_ovf", bus.x_ovf, 1);
        chk("ovf_y_ovf", bus.y_ovf, 0);
        chk("ovf_dx", bus.dx, 9'h07F);
        chk("ovf_cursor_x", bus.cursor_x, 0);

        // Right edge clamp
        pkt(8'h08, 8'hFF, 8'h00);
        pkt(8'h08, 8'hFF, 8'h00);
        chk("cr2_cursor_x", bus.cursor_x, 510);
        pkt(8'h08, 8'hFF, 8'h00);
        chk("cr3_cursor_x", bus.cursor_x, 639);

        // Recenter coincident with byte 2
        send(8'h09);
        send(8'h03);
        @(negedge clk);
        bus.received_data    = 8'h01;
        bus.received_data_en = 1'b1;
        bus.recenter         = 1'b1;
        @(negedge clk);
        bus.received_data_en = 1'b0;
        bus.recenter         = 1'b0;
        chk("rc_pkt_valid", bus.pkt_valid, 1);
        chk("rc_cursor_x", bus.cursor_x, 320);
        chk("rc_cursor_y", bus.cursor_y, 240);
        chk("rc_dx", bus.dx, 9'h003);
        chk("rc_dy", bus.dy, 9'h001);
        chk("rc_btn_left", bus.btn_left, 1);

        // Async reset mid-packet
        pkt(8'h08, 8'h10, 8'h00);
        send(8'h08);
        send(8'h05);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_cursor_x", bus.cursor_x, 320);
        chk("ar_cursor_y", bus.cursor_y, 240);
        chk("ar_sync_err", bus.sync_err, 0);
        chk("ar_dx", bus.dx, 0);
        chk("ar_btn_left", bus.btn_left, 0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h07);
        chk("ar_no_partial", bus.pkt_valid, 0);
        chk("ar_realign_err", bus.sync_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_mouse_packet_decoder.md
Name: ps2_mouse_packet_decoder

Overview:
- Consumes the byte stream from the PS/2 mouse receiver (8-bit data plus a one-cycle valid strobe).
- Assembles standard 3-byte PS/2 mouse packets and realigns to byte 0 when the stream loses sync.
- Decodes button states and signed X/Y deltas.
- Maintains a clamped on-screen cursor position for the game engine's sprite/render logic.

Parameters:
- X_W, 10, cursor_x width.
- Y_W, 10, cursor_y width.
- SCREEN_W, 640, horizontal extent; cursor_x range 0..SCREEN_W-1.
- SCREEN_H, 480, vertical extent; cursor_y range 0..SCREEN_H-1.
- INIT_X, 320, cursor_x after reset or recenter.
- INIT_Y, 240, cursor_y after reset or recenter.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes of one packet (20 ms at 50 MHz).
- SHIFT, 0, sensitivity; deltas are arithmetic-shifted right by SHIFT before being applied to the cursor.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- received_data  in  8  byte from PS/2 receiver.
- received_data_en  in  1  one-cycle strobe; received_data is valid in that cycle.
- recenter  in  1  synchronous request to load INIT_X/INIT_Y.
- pkt_valid  out  1  one-cycle pulse when a complete packet has been decoded.
- btn_left  out  1  byte0[0].
- btn_right  out  1  byte0[1].
- btn_middle  out  1  byte0[2].
- dx  out  9  signed X delta {byte0[4], byte1}.
- dy  out  9  signed Y delta {byte0[5], byte2}; positive = mouse moved up.
- x_ovf  out  1  byte0[6].
- y_ovf  out  1  byte0[7].
- cursor_x  out  X_W  cursor column.
- cursor_y  out  Y_W  cursor row; 0 = top.
- sync_err  out  8  saturating count of discarded bytes and timeouts.

Behaviour:
- Reset values:
  - pkt_valid, buttons, dx, dy, x_ovf, y_ovf = 0.
  - cursor_x = INIT_X, cursor_y = INIT_Y.
  - sync_err = 0; FSM = WAIT_B0; timeout counter = 0.
- Reset asserted mid-packet aborts the packet. No partial packet is ever reported.
- FSM:
  - WAIT_B0: on strobe with received_data[3]=1, store byte0, clear timeout counter, go to WAIT_B1. On strobe with bit3=0, discard the byte, increment sync_err, stay.
  - WAIT_B1: on strobe, store byte1, clear counter, go to WAIT_B2.
  - WAIT_B2: on strobe, decode the packet using stored byte0, byte1 and the current received_data, then go to WAIT_B0.
  - In WAIT_B1/WAIT_B2 the counter increments each cycle without a strobe. When it reaches TIMEOUT_CYCLES-1, return to WAIT_B0, discard stored bytes and increment sync_err.
  - A strobe in the same cycle as timeout expiry is accepted; the strobe wins and the timeout does not fire.
- sync_err saturates at 255 and never wraps.
- Decode latency:
  - Outputs are registered on the clock edge that samples the byte-2 strobe.
  - pkt_valid is high for exactly the following cycle.
  - dx, dy, buttons and ovf flags hold until the next packet.
  - cursor_x/cursor_y update in the same cycle pkt_valid is high.
- Cursor arithmetic:
  - Work in signed X_W+2 / Y_W+2 bits.
  - Effective delta = (ovf flag ? 0 : delta >>> SHIFT), per axis.
  - new_x = cursor_x + eff_dx.
  - new_y = cursor_y - eff_dy (screen Y grows downward).
  - Clamp: result < 0 gives 0; result > SCREEN_W-1 (SCREEN_H-1 for Y) gives that maximum. No wrap-around.
- recenter:
  - Loads INIT_X/INIT_Y on the next edge.
  - If it coincides with a packet decode, recenter wins for the cursor. Buttons, deltas and pkt_valid still update.
- received_data is sampled only in strobe cycles; changes without a strobe are ignored.

Test Plan:
- Reset, then bytes 0x08, 0x05, 0x03 -> pkt_valid one cycle after 3rd strobe; dx=+5, dy=+3, buttons 0; cursor (325,237).
- Bytes 0x19, 0xFB, 0x00 -> btn_left=1, dx=-5 (0x1FB); cursor_x decreases by 5; dy=0.
- Strobe 0x00 (bit3=0) followed by a valid packet -> sync_err=1; the valid packet decodes correctly after realignment.
- Byte0, byte1, then no strobe for TIMEOUT_CYCLES -> FSM returns to WAIT_B0, sync_err increments, no pkt_valid. A fresh packet then decodes normally.
- Cursor at (0,479) with packet dx=-100, dy=-100 -> cursor stays (0,479). Packet 0x48, 0x7F, 0x00 (x_ovf set) -> cursor_x unchanged, x_ovf=1.
- recenter asserted in the same cycle as a byte-2 strobe -> cursor=(320,240), pkt_valid=1 with decoded dx/dy. Async reset mid-packet -> all outputs return to reset values immediately.
